// File: rtl/turn_switch_conditioner.sv
// rtl/turn_switch_conditioner.sv - synchronise, debounce and arbitrate the right/left turn switches
// Produces mutually exclusive turn requests with a sticky conflict state for the tail-light sequencer.
module turn_switch_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw0,
    input  logic       sw1,
    output logic       right_req,
    output logic       left_req,
    output logic       conflict,
    output logic       req_change,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RIGHT    = 2'b01,
        LEFT     = 2'b10,
        CONFLICT = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_meta;
    logic [1:0]       sync_q;
    logic [1:0]       deb;
    logic [CNT_W-1:0] cnt [2];
    state_t           state;
    state_t           state_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= {sw1, sw0};
            sync_q    <= sync_meta;
        end
    end

    // Any sample that agrees with the accepted value restarts the stability count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb <= '0;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync_q[i] != deb[i]) begin
                    if (cnt[i] == CNT_LAST) begin
                        deb[i] <= sync_q[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, RIGHT, LEFT: begin
                if (deb[0] && deb[1]) state_nxt = CONFLICT;
                else if (deb[0])      state_nxt = RIGHT;
                else if (deb[1])      state_nxt = LEFT;
                else                  state_nxt = IDLE;
            end
            CONFLICT: begin
                // Releasing only one switch keeps the error latched.
                if (!deb[0] && !deb[1]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            right_req  <= 1'b0;
            left_req   <= 1'b0;
            conflict   <= 1'b0;
            req_change <= 1'b0;
        end else begin
            state      <= state_nxt;
            right_req  <= (state_nxt == RIGHT);
            left_req   <= (state_nxt == LEFT);
            conflict   <= (state_nxt == CONFLICT);
            req_change <= (state_nxt != state);
        end
    end

    assign state_o = state;

endmodule
